// File: rtl/cpuclk_gen.sv
// CPU clock generator: programmable half-period divider with hold stretch.
// Optional single-step gating is compiled in with CPUCLK_STEP_EN.
module cpuclk_gen #(
    parameter int WIDTH        = 8,
    parameter int HALF_DEFAULT = 128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             div_wr,
    input  logic [WIDTH-1:0] div_data,
    input  logic             step_mode,
    input  logic             step,
    output logic             clockout,
    output logic             rise,
    output logic             fall,
    output logic             stalled,
    output logic [WIDTH-1:0] half_cur
);

    localparam logic [WIDTH-1:0] HALF_INIT = WIDTH'(HALF_DEFAULT);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] half_pend;
    logic [WIDTH-1:0] div_clamp;
    logic             pend_valid;
    logic             term;
    logic             blocked;
    logic             fall_now;

    assign div_clamp = (div_data == '0) ? ONE : div_data;
    assign term      = (cnt == half_cur - ONE);
    assign fall_now  = term && clockout && !blocked;

`ifdef CPUCLK_STEP_EN
    logic step_ok;

    assign blocked = hold | (step_mode & ~step_ok);

    // A granted step is consumed by the fall it releases; extra pulses drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_ok <= 1'b0;
        end else if (fall_now) begin
            step_ok <= 1'b0;
        end else if (step) begin
            step_ok <= 1'b1;
        end
    end
`else
    logic unused_step;

    assign unused_step = step_mode ^ step;
    assign blocked     = hold;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            clockout   <= 1'b1;
            half_cur   <= HALF_INIT;
            half_pend  <= HALF_INIT;
            pend_valid <= 1'b0;
            stalled    <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (div_wr) begin
                half_pend <= div_clamp;
            end
            if (div_wr) begin
                pend_valid <= 1'b1;
            end else if (term && !clockout) begin
                pend_valid <= 1'b0;
            end
            if (!term) begin
                cnt <= cnt + ONE;
            end else if (!clockout) begin
                // Divisor switches only here, so every phase is whole.
                cnt      <= '0;
                clockout <= 1'b1;
                rise     <= 1'b1;
                if (pend_valid) begin
                    half_cur <= half_pend;
                end
            end else if (blocked) begin
                stalled <= 1'b1;
            end else begin
                cnt      <= '0;
                clockout <= 1'b0;
                fall     <= 1'b1;
                stalled  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpuclk_gen.sv
// Directed bench for cpuclk_gen with HALF_DEFAULT=4.
// Step-gating vectors run only when CPUCLK_STEP_EN is defined.
module tb_cpuclk_gen;

    localparam int W = 8;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic         hold      = 1'b0;
    logic         div_wr    = 1'b0;
    logic [W-1:0] div_data  = '0;
    logic         step_mode = 1'b0;
    logic         step      = 1'b0;
    logic         clockout;
    logic         rise;
    logic         fall;
    logic         stalled;
    logic [W-1:0] half_cur;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int f;
    logic [15:0] t_clk;
    logic [15:0] t_rise;
    logic [15:0] t_fall;

    cpuclk_gen #(
        .WIDTH       (W),
        .HALF_DEFAULT(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .hold     (hold),
        .div_wr   (div_wr),
        .div_data (div_data),
        .step_mode(step_mode),
        .step     (step),
        .clockout (clockout),
        .rise     (rise),
        .fall     (fall),
        .stalled  (stalled),
        .half_cur (half_cur)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic count_falls(input int n, output int cnt_f);
        cnt_f = 0;
        while (cyc < n) begin
            tick();
            cnt_f += int'(fall);
        end
    endtask

    task automatic clr_trace();
        t_clk  = '0;
        t_rise = '0;
        t_fall = '0;
    endtask

    task automatic rec(input int i);
        t_clk[i]  = clockout;
        t_rise[i] = rise;
        t_fall[i] = fall;
    endtask

    initial begin
        tick();
        tick();
        check("rst_clk", clockout, 1);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_stall", stalled, 0);
        check("rst_half", half_cur, 4);
        reset = 1'b0;
        cyc = 0;

        // S0..S9: 4 high, 4 low, rise at S8
        clr_trace();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            rec(i);
        end
        check("t1_clk", t_clk, 16'h030F);
        check("t1_fall", t_fall, 16'h0010);
        check("t1_rise", t_rise, 16'h0100);

        // div_wr=2 mid-high at S9; applies at rise S16
        div_wr = 1'b1;
        div_data = 8'd2;
        tick();
        div_wr = 1'b0;
        clr_trace();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            rec(i);
            if (i == 5) check("t2_half_old", half_cur, 4);
            if (i == 6) check("t2_half_new", half_cur, 2);
        end
        check("t2_clk", t_clk, 16'h0CC3);
        check("t2_rise", t_rise, 16'h0440);
        check("t2_fall", t_fall, 16'h0104);

        // div_wr=0 at S21 -> half 1 from rise at S24
        div_wr = 1'b1;
        div_data = 8'd0;
        tick();
        div_wr = 1'b0;
        clr_trace();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            rec(i);
        end
        check("t3_clk", t_clk, 16'h0054);
        check("t3_rise", t_rise, 16'h0054);
        check("t3_fall", t_fall, 16'h00A9);
        check("t3_half", half_cur, 1);

        // back to 4, written at S29, applied at S32
        div_wr = 1'b1;
        div_data = 8'd4;
        tick();
        div_wr = 1'b0;
        run_to(32);
        check("rs_rise", rise, 1);
        check("rs_half", half_cur, 4);
        run_to(36);
        check("rs_fall", fall, 1);

        // hold raised in low phase at S36 for 20 edges
        hold = 1'b1;
        run_to(40);
        check("h_rise", rise, 1);
        run_to(43);
        check("h_hi_stall", stalled, 0);
        tick();
        check("h_clk44", clockout, 1);
        check("h_stall44", stalled, 1);
        check("h_nofall44", fall, 0);
        count_falls(56, f);
        check("h_nofalls", f, 0);
        check("h_stall56", stalled, 1);
        hold = 1'b0;
        tick();
        check("h_rel_clk", clockout, 0);
        check("h_rel_fall", fall, 1);
        check("h_rel_stall", stalled, 0);
        hold = 1'b1;
        run_to(60);
        check("h_low60", clockout, 0);
        tick();
        check("h_rise61", rise, 1);

        // stall again, pend 9, then reset
        run_to(65);
        check("r_stall65", stalled, 1);
        tick();
        div_wr = 1'b1;
        div_data = 8'd9;
        tick();
        div_wr = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("r_clk", clockout, 1);
        check("r_stall", stalled, 0);
        check("r_half", half_cur, 4);
        check("r_rise", rise, 0);
        reset = 1'b0;
        hold = 1'b0;
        run_to(72);
        check("r_hi72", clockout, 1);
        tick();
        check("r_fall73", fall, 1);
        run_to(77);
        check("r_rise77", rise, 1);
        check("r_half77", half_cur, 4);

`ifdef CPUCLK_STEP_EN
        div_wr = 1'b1;
        div_data = 8'd2;
        tick();
        div_wr = 1'b0;
        run_to(81);
        check("s_fall81", fall, 1);
        step_mode = 1'b1;
        run_to(85);
        check("s_half85", half_cur, 2);
        run_to(87);
        check("s_stall87", stalled, 1);
        run_to(90);
        check("s_clk90", clockout, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("s_fall92", fall, 1);
        run_to(94);
        check("s_rise94", rise, 1);
        run_to(96);
        check("s_stall96", stalled, 1);
        check("s_clk96", clockout, 1);
        count_falls(99, f);
        check("s_nofall", f, 0);
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        check("s2_fall101", fall, 1);
        count_falls(112, f);
        check("s2_falls", f, 0);
        check("s2_stall", stalled, 1);
`else
        run_to(81);
        check("r_fall81", fall, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
